// File: rtl/pdp1_pkg.sv
// Shared definitions for the PDP-1 extended core memory: op codes, core-cycle states, widths.
// Words use descending ranges; PDP-1 bit 0 (MSB) maps to bit 17 here, ma bit 6 to bit 11.
package pdp1_pkg;

  localparam int FIELD_W = 3;
  localparam int MA_W    = 12;
  localparam int WORD_W  = 18;
  localparam int PCNT_W  = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_RMW   = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RSTRB = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WRITE = 3'd4,
    ST_INHIB = 3'd5
  } mem_state_e;

endpackage

// File: rtl/mem_phase_timer.sv
// Core phase counter: counts clk cycles inside one memory phase, flags the last cycle (tc)
// and the cycle just before the strobe tap so the strobe can be registered.
module mem_phase_timer
  import pdp1_pkg::*;
#(
  parameter int PHASE_CYC  = 8,
  parameter int STROBE_DLY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic [PCNT_W-1:0] cnt,
  output logic              tc,
  output logic              tap_pre
);

  localparam int CW = PCNT_W + 1;

  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PCNT_W'(1);
    end
  end

  // Widened so the compare cannot alias when cnt sits at its top value.
  assign cnt_nxt = {1'b0, cnt} + CW'(1);
  assign tc      = (cnt == PCNT_W'(PHASE_CYC - 1));
  assign tap_pre = (cnt_nxt == CW'(STROBE_DLY));

endmodule

// File: rtl/core_mem_ext.sv
// Extended core memory: read/restore, clear/write and split read-modify-write core cycles.
// Ops 0/1 finish 4*PHASE_CYC+1 cycles after start; op 2 parks in HOLD until resume.
module core_mem_ext
  import pdp1_pkg::*;
#(
  parameter int NFIELDS    = 4,
  parameter int PHASE_CYC  = 8,
  parameter int STROBE_DLY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [FIELD_W-1:0] field,
  input  logic [MA_W-1:0]    ma,
  input  logic [WORD_W-1:0]  mb,
  input  logic               resume,
  output logic [WORD_W-1:0]  mbm,
  output logic               strobe,
  output logic               done,
  output logic               nxm,
  output logic               overrun,
  output logic               busy,
  output logic               r,
  output logic               rs,
  output logic               w,
  output logic               i
);

  localparam int                 DEPTH  = NFIELDS * 4096;
  localparam int                 ADDR_W = $clog2(DEPTH);
  localparam logic [FIELD_W:0]   NF     = (FIELD_W + 1)'(NFIELDS);

  mem_state_e          state;
  mem_op_e             op_q;
  logic [FIELD_W-1:0]  field_q;
  logic [MA_W-1:0]     ma_q;
  logic [WORD_W-1:0]   wdat;
  logic [WORD_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   addr;
  logic [PCNT_W-1:0]   cnt;
  logic                tc;
  logic                tap_pre;
  logic                clr;
  logic                strobe_nxt;
  logic                mem_we;
  logic                req_bad;

  logic [WORD_W-1:0]   mem [0:DEPTH-1];

  // ma is a full 12-bit field offset, so it wraps inside the field by construction.
  assign addr = ADDR_W'({field_q, ma_q});

  assign clr        = (state == ST_IDLE) || (state == ST_HOLD) || tc;
  assign strobe_nxt = ((state == ST_RSTRB) && tap_pre) ||
                      ((STROBE_DLY == 0) && (state == ST_READ) && tc);
  assign mem_we     = !reset && (state == ST_INHIB) && tc;
  assign req_bad    = ({1'b0, field} >= NF) || (mem_op_e'(op) == OP_RSVD);

  mem_phase_timer #(
    .PHASE_CYC  (PHASE_CYC),
    .STROBE_DLY (STROBE_DLY)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .cnt     (cnt),
    .tc      (tc),
    .tap_pre (tap_pre)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wdat;
    end
    rd_q <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_READ;
      field_q <= '0;
      ma_q    <= '0;
      wdat    <= '0;
      mbm     <= '0;
      r       <= 1'b0;
      rs      <= 1'b0;
      w       <= 1'b0;
      i       <= 1'b0;
      busy    <= 1'b0;
      strobe  <= 1'b0;
      done    <= 1'b0;
      nxm     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      strobe  <= strobe_nxt;
      done    <= 1'b0;
      nxm     <= 1'b0;
      // A start landing on the done cycle still belongs to the finishing cycle.
      overrun <= start && ((state != ST_IDLE) || done);

      if (strobe_nxt) begin
        mbm <= (op_q == OP_CLEAR) ? '0 : rd_q;
        if (op_q == OP_READ) begin
          wdat <= rd_q;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            if (req_bad) begin
              nxm  <= 1'b1;
              done <= 1'b1;
            end else begin
              op_q    <= mem_op_e'(op);
              field_q <= field;
              ma_q    <= ma;
              state   <= ST_READ;
              r       <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (tc) begin
            state <= ST_RSTRB;
            r     <= 1'b0;
            rs    <= 1'b1;
          end
        end
        ST_RSTRB: begin
          if (tc) begin
            rs <= 1'b0;
            if (op_q == OP_RMW) begin
              state <= ST_HOLD;
            end else begin
              state <= ST_WRITE;
              w     <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (resume) begin
            state <= ST_WRITE;
            w     <= 1'b1;
          end
        end
        ST_WRITE: begin
          if ((cnt == '0) && (op_q != OP_READ)) begin
            wdat <= mb;
          end
          if (tc) begin
            state <= ST_INHIB;
            i     <= 1'b1;
          end
        end
        ST_INHIB: begin
          if (tc) begin
            state <= ST_IDLE;
            w     <= 1'b0;
            i     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_ext.sv
// Scoreboard bench for core_mem_ext: expectations queued at start, retired on strobe/i/done.
module tb_core_mem_ext;

  localparam int P  = 8;
  localparam int SD = 3;
  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        reset, start, resume;
  logic [1:0]  op;
  logic [2:0]  field;
  logic [11:0] ma;
  logic [17:0] mb, mbm;
  logic        strobe, done, nxm, overrun, busy, r, rs, w, i;

  core_mem_ext #(.NFIELDS(NF), .PHASE_CYC(P), .STROBE_DLY(SD)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .field(field), .ma(ma),
    .mb(mb), .resume(resume), .mbm(mbm), .strobe(strobe), .done(done), .nxm(nxm),
    .overrun(overrun), .busy(busy), .r(r), .rs(rs), .w(w), .i(i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] mbm;
    int          strobe_at;
    int          i_at;
    int          done_at;
    logic        nxm;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [17:0] model [int];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_cnt = 0;
  int          ovr_cnt = 0;
  logic        i_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {37'd0, r, rs, w, i, busy, strobe, done, nxm, overrun, mbm};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      i_q = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (overrun) ovr_cnt++;
      if (strobe) begin
        if (sb.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          chk("strobe_at", cyc, sb[0].strobe_at);
          chk("mbm", mbm, sb[0].mbm);
        end
      end
      if (i && !i_q) begin
        if (sb.size() == 0) chk("i_unexpected", 1, 0);
        else chk("i_rise_at", cyc, sb[0].i_at);
      end
      i_q = i;
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("done_at", cyc, mon_e.done_at);
          chk("nxm", nxm, mon_e.nxm);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [2:0] f, input logic [11:0] a,
                       input logic [17:0] d, input int hold_wait, input logic [17:0] d2,
                       output int c);
    exp_t e;
    int   ad;
    int   h;
    c  = cyc;
    ad = {f, a};
    e.nxm = (f >= NF) || (o == 2'd3);
    h = (o == 2'd2) ? hold_wait + 1 : 0;
    if (e.nxm) begin
      e.mbm = '0; e.strobe_at = -1; e.i_at = -1; e.done_at = c + 1;
    end else begin
      e.mbm       = (o == 2'd1) ? 18'd0 : (model.exists(ad) ? model[ad] : 18'd0);
      e.strobe_at = c + 1 + P + SD;
      e.i_at      = c + 1 + 3 * P + h;
      e.done_at   = c + 1 + 4 * P + h;
      if (o == 2'd1) model[ad] = d;
      else if (o == 2'd2) model[ad] = d2;
    end
    sb.push_back(e);
    op = o; field = f; ma = a; mb = d; start = 1'b1;
    step();
    start = 1'b0;
    if (!e.nxm && o == 2'd2) begin
      while (cyc < c + 1 + 2 * P + hold_wait) step();
      resume = 1'b1; mb = d2;
      step();
      resume = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", n >= 300, 0);
    step();
  endtask

  task automatic run(input logic [1:0] o, input logic [2:0] f, input logic [11:0] a,
                     input logic [17:0] d);
    int c;
    issue(o, f, a, d, 0, 18'd0, c);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int c, b0, o0;
    reset = 1'b1; start = 1'b0; resume = 1'b0; op = '0; field = '0; ma = '0; mb = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outs", outs(), 0);

    // Preloads via clear-write, then read back.
    run(2'd1, 3'd1, 12'o100, 18'o123456);
    run(2'd1, 3'd0, 12'o0, 18'o111111);
    run(2'd0, 3'd1, 12'o100, 18'd0);
    run(2'd0, 3'd1, 12'o100, 18'd0);

    run(2'd1, 3'd3, 12'o7777, 18'o777777);
    run(2'd0, 3'd3, 12'o7777, 18'd0);
    run(2'd0, 3'd0, 12'o0, 18'd0);

    // Split read-modify-write with 50 idle HOLD cycles; mb changes only at resume.
    run(2'd1, 3'd2, 12'o5, 18'o070707);
    issue(2'd2, 3'd2, 12'o5, 18'o777000, 50, 18'o000001, c);
    wait_idle();
    run(2'd0, 3'd2, 12'o5, 18'd0);

    // Non-existent field / reserved op: nxm+done next cycle, busy never rises, no write.
    b0 = busy_cnt;
    run(2'd0, 3'd5, 12'o100, 18'd0);
    run(2'd1, 3'd4, 12'o0, 18'o222222);
    run(2'd3, 3'd0, 12'o0, 18'o333333);
    chk("nxm_busy_cycles", busy_cnt - b0, 0);
    run(2'd0, 3'd0, 12'o0, 18'd0);

    // Stray resume during READ of op 0 changes nothing.
    issue(2'd0, 3'd1, 12'o100, 18'd0, 0, 18'd0, c);
    repeat (3) step();
    resume = 1'b1;
    step();
    resume = 1'b0;
    wait_idle();

    // Start while busy.
    o0 = ovr_cnt;
    issue(2'd0, 3'd3, 12'o7777, 18'd0, 0, 18'd0, c);
    while (cyc < c + 10) step();
    op = 2'd1; field = 3'd1; ma = 12'o100; mb = 18'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    chk("overrun_busy", ovr_cnt - o0, 1);
    run(2'd0, 3'd1, 12'o100, 18'd0);

    // Start on the done cycle.
    o0 = ovr_cnt;
    issue(2'd0, 3'd0, 12'o0, 18'd0, 0, 18'd0, c);
    while (cyc < c + 1 + 4 * P) step();
    chk("done_cycle", done, 1);
    op = 2'd1; field = 3'd2; ma = 12'o5; mb = 18'o444444; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    chk("overrun_on_done", ovr_cnt - o0, 1);

    // Reset during WRITE abandons the cycle.
    run(2'd1, 3'd0, 12'o200, 18'o555555);
    issue(2'd1, 3'd0, 12'o200, 18'o000777, 0, 18'd0, c);
    while (cyc < c + 1 + 2 * P + 3) step();
    chk("in_write", w && !i, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    model[{3'd0, 12'o200}] = 18'o555555;
    chk("reset_mid_outs", outs(), 0);
    run(2'd0, 3'd0, 12'o200, 18'd0);
    run(2'd0, 3'd2, 12'o5, 18'd0);

    repeat (5) step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
